multi_change_detector: RTL and testbench
========================================

Name: multi_change_detector

Overview:
- Multi-channel successor to the single-vector change detector.
- Watches NUM_CH independent WIDTH-bit channels. Each channel has a selectable detect mode: off, any change, increase or decrease.
- Per channel it produces a one-cycle event pulse, a sticky event flag, and a saturating event counter.
- Flags are masked and ORed into one interrupt. The block sits between status/sensor buses and the interrupt/CSR logic.

Parameters:
- NUM_CH, 4, number of monitored channels
- WIDTH, 8, bits per channel
- CNT_W, 8, width of each per-channel event counter
- HOLDOFF, 4, suppression window in cycles after an event; used only when CHG_DET_HOLDOFF_EN is defined; must be at least 1

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global detect enable
- sig  input  NUM_CH*WIDTH  channel c occupies sig[c*WIDTH +: WIDTH]
- mode  input  2*NUM_CH  channel c mode mode[2c+1:2c]: 00 off, 01 any change, 10 increase, 11 decrease
- clr  input  NUM_CH  write-1-to-clear for flag[c] and count[c]
- irq_mask  input  NUM_CH  1 = flag[c] contributes to irq
- pulse  output  NUM_CH  one-cycle event strobe per channel (registered)
- flag  output  NUM_CH  sticky event flag per channel (registered)
- count  output  NUM_CH*CNT_W  channel c event count, count[c*CNT_W +: CNT_W] (registered)
- irq  output  1  |(flag & irq_mask), combinational from registered flags

Behaviour:
- Reset (asynchronous, rst_n=0): prev sample, pulse, flag, count, irq and per-channel prev_valid all 0. Reset mid-operation discards all history immediately.
- Every edge: prev[c] <= sig[c] and prev_valid[c] <= 1, regardless of en or mode. Prev tracking never stalls, so re-enabling the block cannot fire on stale data.
- Qualifying event on channel c at an edge requires all of:
  - prev_valid[c]=1, so the first edge after reset never fires;
  - en=1;
  - the mode condition holds.
- Mode conditions:
  - 01: sig[c] != prev[c]
  - 10: sig[c] > prev[c], unsigned
  - 11: sig[c] < prev[c], unsigned
  - 00: never
- Mode is sampled on the same edge as sig; a mode change takes effect on that edge.
- Latency: if sig changes before edge N and the change meets the mode, pulse[c]=1 for exactly the cycle after edge N.
- pulse: sustained changes every cycle give pulse high every cycle. No change gives pulse 0 at the next edge.
- flag[c]: set on event, held until clr[c]=1. Event and clr on the same edge: event wins, flag stays 1.
- count[c]:
  - +1 per event; saturates at 2^CNT_W-1 and never wraps.
  - clr[c] zeroes it. Event and clr on the same edge: count = 1.
- Channels are fully independent; no cross-channel priority.
- irq: combinational from registered flags. Changing irq_mask alters irq in the same cycle; flags are unaffected.

Optional Feature:
- Macro: CHG_DET_HOLDOFF_EN.
- Defined:
  - Each channel has a holdoff counter, loaded with HOLDOFF on an event.
  - While the counter is nonzero it decrements each edge, and qualifying events on that channel are suppressed: no pulse, flag or count effect.
  - prev still updates every edge.
  - Reset and clr[c] zero the channel's counter.
  - Result: events on one channel are at least HOLDOFF+1 cycles apart.
- Not defined: no holdoff logic; every qualifying edge is an event.

Test Plan:
- Reset release: NUM_CH=4, WIDTH=8, all modes 01, en=1, sig=0x11223344 constant from reset -> no pulse, flag=0, irq=0 on the first edge after reset and thereafter.
- Any-change mode: ch0 mode 01, ch0 sig 0x10->0x11 before edge N -> pulse[0]=1 for one cycle after N; flag[0]=1 held; count[0]=1; other channels idle.
- Increase/decrease modes: ch1 mode 10, ch2 mode 11, drive 0x05->0x09->0x03 on both -> ch1 one event (at 0x09); ch2 one event (at 0x03).
- Saturation and clear: CNT_W=8, ch3 toggles every cycle for 300 cycles -> count[3]=0xFF. Then clr[3] together with an event -> flag[3]=1, count[3]=1. Then clr[3] alone -> flag[3]=0, count[3]=0.
- Enable and irq: en=0 while ch0 changes -> no events. en=1 with no further change -> no event. Then irq_mask=0001 and a ch0 event -> irq=1. Mask cleared -> irq=0 with flag[0] still 1.
- Holdoff (CHG_DET_HOLDOFF_EN, HOLDOFF=4): ch0 toggles every cycle for 12 cycles -> pulses exactly 5 cycles apart. Mid-run reset -> all outputs 0 immediately; no pulse on the first post-reset edge.

Source files
------------

// File: rtl/multi_change_detector.sv
// multi_change_detector: per-channel off/any/increase/decrease event detector with pulse, sticky flag, saturating count and masked irq; CHG_DET_HOLDOFF_EN adds per-channel post-event holdoff
module multi_change_detector #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH*WIDTH-1:0] sig,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       irq_mask,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    irq
);
  logic [NUM_CH*WIDTH-1:0] prev;
  logic [NUM_CH-1:0] prev_valid, hit, evt;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] s, p;
    logic [1:0] m;
    logic [CNT_W-1:0] cnt;
    assign s = sig[c*WIDTH +: WIDTH];
    assign p = prev[c*WIDTH +: WIDTH];
    assign m = mode[2*c +: 2];
    assign hit[c] = prev_valid[c] && en &&
                    (m == 2'b01 ? s != p : m == 2'b10 ? s > p : m == 2'b11 ? s < p : 1'b0);
`ifdef CHG_DET_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [HW-1:0] hold;
    assign evt[c] = hit[c] && hold == '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hold <= '0;
      else if (evt[c]) hold <= HW'(HOLDOFF);
      else if (clr[c]) hold <= '0;
      else if (hold != '0) hold <= hold - 1'b1;
`else
    assign evt[c] = hit[c];
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (evt[c]) cnt <= clr[c] ? CNT_W'(1) : cnt + CNT_W'(cnt != '1);
      else if (clr[c]) cnt <= '0;
    assign count[c*CNT_W +: CNT_W] = cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= '0;
      pulse      <= '0;
      flag       <= '0;
    end else begin
      prev       <= sig;
      prev_valid <= '1;
      pulse      <= evt;
      flag       <= evt | (flag & ~clr);
    end
  assign irq = |(flag & irq_mask);
endmodule

// File: tb/tb_multi_change_detector.sv
// tb_multi_change_detector: vector table, corner sequences and randomized run against a behavioural model
module tb_multi_change_detector;
  localparam int N = 4, W = 8, CW = 8, HOLD = 4;
  logic clk = 0, rst_n = 0, en = 0, irq;
  logic [N*W-1:0] sig = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0] clr = '0, irq_mask = '0, pulse, flag;
  logic [N*CW-1:0] count;
  int tests = 0, fails = 0;
  int mprev[N], mcnt[N], mhold[N];
  bit mvalid[N], mflag[N], mpulse[N];

  multi_change_detector #(.NUM_CH(N), .WIDTH(W), .CNT_W(CW), .HOLDOFF(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig), .mode(mode), .clr(clr),
    .irq_mask(irq_mask), .pulse(pulse), .flag(flag), .count(count), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      mprev[c] = 0; mcnt[c] = 0; mhold[c] = 0;
      mvalid[c] = 0; mflag[c] = 0; mpulse[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < N; c++) begin
      int s = int'(sig[c*W +: W]);
      int md = int'(mode[2*c +: 2]);
      bit e = mvalid[c] && en &&
              ((md == 1 && s != mprev[c]) || (md == 2 && s > mprev[c]) || (md == 3 && s < mprev[c]));
`ifdef CHG_DET_HOLDOFF_EN
      if (mhold[c] > 0) e = 0;
      if (e) mhold[c] = HOLD;
      else if (clr[c]) mhold[c] = 0;
      else if (mhold[c] > 0) mhold[c]--;
`endif
      mpulse[c] = e;
      mflag[c] = e ? 1'b1 : (clr[c] ? 1'b0 : mflag[c]);
      if (e) mcnt[c] = clr[c] ? 1 : (mcnt[c] + 1 > 2**CW - 1 ? 2**CW - 1 : mcnt[c] + 1);
      else if (clr[c]) mcnt[c] = 0;
      mprev[c] = s;
      mvalid[c] = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] ep, ef;
    logic [N*CW-1:0] ec;
    for (int c = 0; c < N; c++) begin
      ep[c] = mpulse[c];
      ef[c] = mflag[c];
      ec[c*CW +: CW] = CW'(mcnt[c]);
    end
    chk({tag, " pulse"}, 32'(pulse), 32'(ep));
    chk({tag, " flag"}, 32'(flag), 32'(ef));
    chk({tag, " count"}, 32'(count), 32'(ec));
    chk({tag, " irq"}, 32'(irq), 32'(|(ef & irq_mask)));
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("reset outputs", {26'(count), pulse[1:0], flag[1:0], irq, 1'b0},
        32'h0);
    chk("reset pulse/flag", 32'({pulse, flag}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    logic [31:0] sig;
    logic [7:0]  mode;
    logic [3:0]  clr, mask;
    logic        en;
    logic [3:0]  p, f;
    logic [31:0] cnt;
    logic        irq;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{32'h11223344, 8'h55, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0};
    tbl[1]  = '{32'h11223344, 8'h55, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0};
    tbl[2]  = '{32'h11223310, 8'h55, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 32'h00000001, 1'b0};
    tbl[3]  = '{32'h11223311, 8'h55, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 32'h00000002, 1'b0};
    tbl[4]  = '{32'h11223311, 8'h55, 4'h0, 4'h0, 1'b1, 4'h0, 4'h1, 32'h00000002, 1'b0};
    tbl[5]  = '{32'h11050511, 8'h00, 4'h0, 4'h0, 1'b1, 4'h0, 4'h1, 32'h00000002, 1'b0};
    tbl[6]  = '{32'h11090911, 8'h79, 4'h0, 4'h0, 1'b1, 4'h2, 4'h3, 32'h00000102, 1'b0};
    tbl[7]  = '{32'h11030311, 8'h79, 4'h0, 4'h0, 1'b1, 4'h4, 4'h7, 32'h00010102, 1'b0};
    tbl[8]  = '{32'h11030311, 8'h79, 4'h7, 4'h0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0};
    tbl[9]  = '{32'h11030322, 8'h55, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0};
    tbl[10] = '{32'h11030322, 8'h55, 4'h0, 4'h1, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0};
    tbl[11] = '{32'h11030333, 8'h55, 4'h0, 4'h1, 1'b1, 4'h1, 4'h1, 32'h00000001, 1'b1};
    tbl[12] = '{32'h11030344, 8'h55, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 32'h00000002, 1'b0};
    tbl[13] = '{32'h11030355, 8'h55, 4'h1, 4'h0, 1'b1, 4'h1, 4'h1, 32'h00000001, 1'b0};
    tbl[14] = '{32'h11030355, 8'h55, 4'h1, 4'h0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0};

    en = 1; mode = 8'h55; sig = 32'h11223344;
    do_reset();
`ifndef CHG_DET_HOLDOFF_EN
    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      sig = tbl[i].sig; mode = tbl[i].mode; clr = tbl[i].clr;
      irq_mask = tbl[i].mask; en = tbl[i].en;
      tick();
      chk({t, " pulse"}, 32'(pulse), 32'(tbl[i].p));
      chk({t, " flag"}, 32'(flag), 32'(tbl[i].f));
      chk({t, " count"}, count, tbl[i].cnt);
      chk({t, " irq"}, 32'(irq), 32'(tbl[i].irq));
    end
    clr = 0; irq_mask = 4'h1; sig[7:0] = 8'h66;
    tick();
    chk("mask irq on", 32'(irq), 32'h1);
    irq_mask = 4'h0;
    #1;
    chk("mask irq off", 32'(irq), 32'h0);
    chk("mask flag kept", 32'(flag[0]), 32'h1);
    irq_mask = 4'h1;
    #1;
    chk("mask irq back", 32'(irq), 32'h1);
    irq_mask = 4'h0;

    do_reset();
    for (int i = 0; i < 300; i++) begin
      sig[31:24] = ~sig[31:24];
      tick();
    end
    check_model("sat");
    chk("sat count3", 32'(count[31:24]), 32'hFF);
    sig[31:24] = ~sig[31:24]; clr = 4'h8;
    tick();
    chk("clr+evt flag3", 32'(flag[3]), 32'h1);
    chk("clr+evt count3", 32'(count[31:24]), 32'h1);
    tick();
    chk("clr flag3", 32'(flag[3]), 32'h0);
    chk("clr count3", 32'(count[31:24]), 32'h0);
    clr = 0;
`else
    begin
      int last, npulse;
      last = -1; npulse = 0;
      tick();
      for (int i = 0; i < 12; i++) begin
        sig[7:0] = ~sig[7:0];
        tick();
        check_model("hold");
        if (pulse[0]) begin
          if (last >= 0) chk("hold gap", 32'(i - last), 32'(HOLD + 1));
          last = i; npulse++;
        end
      end
      chk("hold pulses", 32'(npulse), 32'h3);
    end
`endif

    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++)
        sig[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
      mode = 8'($urandom);
      en = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      irq_mask = 4'($urandom);
      if (i == 200) begin
        rst_n = 0;
        #1;
        chk("midreset outputs", 32'({pulse, flag, irq}), 32'h0);
        chk("midreset count", count, 32'h0);
        tick();
        rst_n = 1;
      end
      tick();
      check_model($sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
